reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for key_n and pll_locked, minimum 2.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to change the debounced key level.
REQ-003 SHALL have parameter HOLD_CYCLES, default 32: cycles sys_reset stays high after all release conditions are met.
REQ-004 SHALL have parameter WDT_CYCLES, default 16777216: watchdog timeout in clk cycles.
REQ-005 SHALL have port clk  input  1  system clock.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high, from the board power-on generator.
REQ-007 SHALL have port key_n  input  1  asynchronous push button, active-low.
REQ-008 SHALL have port pll_locked  input  1  asynchronous PLL lock indication.
REQ-009 SHALL have port wdt_kick  input  1  one-cycle watchdog service pulse, clk domain.
REQ-010 SHALL have port sys_reset  output  1  registered active-high reset to the SoC.
REQ-011 SHALL have port reset_cause  output  2  cause code: 00 power-on, 01 key, 10 PLL loss, 11 watchdog.
REQ-012 SHALL have port key_pressed  output  1  registered debounced key level, 1 = pressed.

Function
REQ-013 key_n and pll_locked SHALL each pass through SYNC_STAGES flops before any use.
REQ-014 Debounce: a counter SHALL increment while the synced key level differs from key_pressed and clear whenever they agree; on reaching DEBOUNCE_CYCLES-1, key_pressed SHALL toggle and the counter SHALL clear.
REQ-015 The FSM SHALL have three states: ASSERT (sys_reset=1), HOLD (sys_reset=1), RUN (sys_reset=0).
REQ-016 ASSERT->HOLD SHALL occur when pll_sync=1 and key_pressed=0; otherwise the FSM SHALL stay in ASSERT.
REQ-017 In HOLD, a counter SHALL run from 0; after exactly HOLD_CYCLES cycles in HOLD the FSM SHALL enter RUN and sys_reset SHALL go low.
REQ-018 HOLD->ASSERT SHALL occur if pll_sync=0 or key_pressed=1; the hold counter SHALL clear.
REQ-019 RUN->ASSERT SHALL occur on pll_sync=0, key_pressed=1, or watchdog expiry; sys_reset SHALL be high in the cycle after detection.
REQ-020 Simultaneous causes SHALL use priority PLL loss > key > watchdog.
REQ-021 reset_cause SHALL update only on HOLD->ASSERT or RUN->ASSERT transitions, and SHALL otherwise hold its value.
REQ-022 All counters SHALL saturate or clear and SHALL never wrap.

Reset
REQ-023 While reset=1, the FSM SHALL be in ASSERT, and sys_reset=1, reset_cause=00 and key_pressed=0.
REQ-024 While reset=1, all counters SHALL be 0, key synchronizer flops SHALL be 1, and pll synchronizer flops SHALL be 0.
REQ-025 reset asserted in any state, including mid-HOLD, SHALL force these values at the next edge.

Configuration
REQ-026 With RESET_SEQ_WDT_EN defined, a watchdog counter SHALL count only in RUN.
REQ-027 The watchdog counter SHALL clear on wdt_kick or when the FSM is outside RUN.
REQ-028 On reaching WDT_CYCLES-1 without a kick, the watchdog SHALL expire; a kick in the same cycle SHALL win.
REQ-029 Without RESET_SEQ_WDT_EN, no watchdog logic SHALL exist, wdt_kick SHALL be ignored, and cause 11 SHALL never occur.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, WDT_CYCLES=100)
REQ-030 Reset high 3 cycles, pll_locked=1, key_n=1 -> sys_reset high 8 cycles after HOLD entry, then low; cause=00.
REQ-031 In RUN, key_n low 3 cycles -> no reset; low 10 cycles -> key_pressed=1, sys_reset=1 next cycle, cause=01, and deassertion 8 cycles after debounced release.
REQ-032 In RUN, pll_locked low 1 cycle -> sys_reset=1 within 3 cycles, cause=10, and re-release after 8 HOLD cycles.
REQ-033 WDT enabled, no kick for 100 RUN cycles -> cause=11 and reset asserted; kick every 50 cycles -> never reset.
REQ-034 Same-cycle pll loss and debounced key -> cause=10.
REQ-035 Reset mid-HOLD -> ASSERT with cause=00 next edge, and hold counter restarts from 0.

Source files
------------

// File: rtl/reset_sequencer.sv
// Board reset sequencer: synchronizes key/PLL, debounces the key, and holds the SoC in reset.
// Optional watchdog is enabled by defining RESET_SEQ_WDT_EN.
module reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 32,
    parameter int WDT_CYCLES      = 16777216
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic       pll_locked,
    input  logic       wdt_kick,
    output logic       sys_reset,
    output logic [1:0] reset_cause,
    output logic       key_pressed
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int DEB_N  = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int HOLD_N = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int DEB_W  = $clog2(DEB_N + 1);
    localparam int HOLD_W = $clog2(HOLD_N + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_N - 1);
    localparam logic [DEB_W-1:0]  DEB_INC   = DEB_W'(32'd1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_N - 1);
    localparam logic [HOLD_W-1:0] HOLD_INC  = HOLD_W'(32'd1);

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_KEY = 2'b01;
    localparam logic [1:0] CAUSE_PLL = 2'b10;
    localparam logic [1:0] CAUSE_WDT = 2'b11;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    logic [SYNC_N-1:0] key_sync_r;
    logic [SYNC_N-1:0] pll_sync_r;
    logic              key_level_s;
    logic              pll_sync_s;
    logic [DEB_W-1:0]  deb_cnt_r;
    logic              key_pressed_r;
    state_t            state_r;
    state_t            state_next_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_next_s;
    logic [1:0]        cause_r;
    logic [1:0]        cause_next_s;
    logic              sys_reset_r;
    logic              wdt_expire_s;

    // Input synchronizers; key idles released, PLL idles unlocked
    always_ff @(posedge clk) begin
        if (reset) begin
            key_sync_r <= {SYNC_N{1'b1}};
            pll_sync_r <= {SYNC_N{1'b0}};
        end else begin
            key_sync_r <= {key_sync_r[SYNC_N-2:0], key_n};
            pll_sync_r <= {pll_sync_r[SYNC_N-2:0], pll_locked};
        end
    end

    assign key_level_s = ~key_sync_r[SYNC_N-1];
    assign pll_sync_s  = pll_sync_r[SYNC_N-1];

    // Key debounce: toggle only after DEB_N consecutive disagreeing cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt_r     <= {DEB_W{1'b0}};
            key_pressed_r <= 1'b0;
        end else if (key_level_s != key_pressed_r) begin
            if (deb_cnt_r == DEB_LAST) begin
                deb_cnt_r     <= {DEB_W{1'b0}};
                key_pressed_r <= ~key_pressed_r;
            end else begin
                deb_cnt_r     <= deb_cnt_r + DEB_INC;
                key_pressed_r <= key_pressed_r;
            end
        end else begin
            deb_cnt_r     <= {DEB_W{1'b0}};
            key_pressed_r <= key_pressed_r;
        end
    end

`ifdef RESET_SEQ_WDT_EN
    localparam int WDT_N = (WDT_CYCLES < 1) ? 1 : WDT_CYCLES;
    localparam int WDT_W = $clog2(WDT_N + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_N - 1);
    localparam logic [WDT_W-1:0] WDT_INC  = WDT_W'(32'd1);

    logic [WDT_W-1:0] wdt_cnt_r;

    // Watchdog runs only in RUN and saturates at its last count
    always_ff @(posedge clk) begin
        if (reset) begin
            wdt_cnt_r <= {WDT_W{1'b0}};
        end else if ((state_r != ST_RUN) || wdt_kick) begin
            wdt_cnt_r <= {WDT_W{1'b0}};
        end else if (wdt_cnt_r != WDT_LAST) begin
            wdt_cnt_r <= wdt_cnt_r + WDT_INC;
        end else begin
            wdt_cnt_r <= wdt_cnt_r;
        end
    end

    assign wdt_expire_s = (state_r == ST_RUN) && !wdt_kick && (wdt_cnt_r == WDT_LAST);
`else
    logic wdt_unused_s;
    assign wdt_unused_s = wdt_kick | (WDT_CYCLES == 32'd0);
    assign wdt_expire_s = 1'b0;
`endif

    // Next-state, hold counter and cause selection (PLL loss > key > watchdog)
    always_comb begin
        state_next_s    = state_r;
        hold_cnt_next_s = {HOLD_W{1'b0}};
        cause_next_s    = cause_r;
        case (state_r)
            ST_ASSERT: begin
                if (pll_sync_s && !key_pressed_r) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_ASSERT;
                end
            end
            ST_HOLD: begin
                if (!pll_sync_s) begin
                    state_next_s = ST_ASSERT;
                    cause_next_s = CAUSE_PLL;
                end else if (key_pressed_r) begin
                    state_next_s = ST_ASSERT;
                    cause_next_s = CAUSE_KEY;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s    = ST_HOLD;
                    hold_cnt_next_s = hold_cnt_r + HOLD_INC;
                end
            end
            ST_RUN: begin
                if (!pll_sync_s) begin
                    state_next_s = ST_ASSERT;
                    cause_next_s = CAUSE_PLL;
                end else if (key_pressed_r) begin
                    state_next_s = ST_ASSERT;
                    cause_next_s = CAUSE_KEY;
                end else if (wdt_expire_s) begin
                    state_next_s = ST_ASSERT;
                    cause_next_s = CAUSE_WDT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_ASSERT;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_ASSERT;
            hold_cnt_r  <= {HOLD_W{1'b0}};
            cause_r     <= CAUSE_POR;
            sys_reset_r <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            hold_cnt_r  <= hold_cnt_next_s;
            cause_r     <= cause_next_s;
            sys_reset_r <= (state_next_s != ST_RUN);
        end
    end

    assign sys_reset   = sys_reset_r;
    assign reset_cause = cause_r;
    assign key_pressed = key_pressed_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, WDT_CYCLES=100.
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       key_n;
    logic       pll_locked;
    logic       wdt_kick;
    logic       sys_reset;
    logic [1:0] reset_cause;
    logic       key_pressed;

    int vec_count;
    int miscompare_count;
    int n;
    logic seen;

`ifdef RESET_SEQ_WDT_EN
    localparam logic [1:0] CAUSE_AFTER_IDLE = 2'b11;
`else
    localparam logic [1:0] CAUSE_AFTER_IDLE = 2'b10;
`endif

    reset_sequencer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .WDT_CYCLES     (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .pll_locked (pll_locked),
        .wdt_kick   (wdt_kick),
        .sys_reset  (sys_reset),
        .reset_cause(reset_cause),
        .key_pressed(key_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miscompare_count++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges until sys_reset reaches level; returns budget if it never does
    task automatic count_until(input logic level, input int budget, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while ((sys_reset !== level) && (cnt < budget));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        vec_count        = 0;
        miscompare_count = 0;
        reset      = 1'b1;
        key_n      = 1'b1;
        pll_locked = 1'b1;
        wdt_kick   = 1'b0;

        // Power-on: 2 sync edges + 1 ASSERT edge + 8 HOLD edges
        repeat (3) tick();
        check_value("rst_sys_reset", 32'(sys_reset), 32'd1);
        check_value("rst_cause", 32'(reset_cause), 32'd0);
        check_value("rst_key_pressed", 32'(key_pressed), 32'd0);
        reset = 1'b0;
        count_until(1'b0, 50, n);
        check_value("por_release_edges", 32'(n), 32'd11);
        check_value("por_cause", 32'(reset_cause), 32'd0);

        // Short press of 3 cycles is filtered out
        seen = 1'b0;
        key_n = 1'b0;
        repeat (3) begin tick(); seen = seen | sys_reset | key_pressed; end
        key_n = 1'b1;
        repeat (10) begin tick(); seen = seen | sys_reset | key_pressed; end
        check_value("short_press_ignored", 32'(seen), 32'd0);

        // 10-cycle press: debounced at edge 6, reset at edge 7
        key_n = 1'b0;
        repeat (5) tick();
        check_value("key_deb_e5", 32'(key_pressed), 32'd0);
        tick();
        check_value("key_deb_e6", 32'(key_pressed), 32'd1);
        check_value("key_sys_e6", 32'(sys_reset), 32'd0);
        tick();
        check_value("key_sys_e7", 32'(sys_reset), 32'd1);
        check_value("key_cause", 32'(reset_cause), 32'd1);
        repeat (3) tick();
        key_n = 1'b1;
        repeat (5) tick();
        check_value("key_release_e15", 32'(key_pressed), 32'd1);
        tick();
        check_value("key_release_e16", 32'(key_pressed), 32'd0);
        // One ASSERT cycle then 8 HOLD cycles
        count_until(1'b0, 50, n);
        check_value("key_rerelease_edges", 32'(n), 32'd9);
        check_value("key_cause_held", 32'(reset_cause), 32'd1);

        // One-cycle PLL loss
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        check_value("pll_sys_e2", 32'(sys_reset), 32'd0);
        tick();
        check_value("pll_sys_e3", 32'(sys_reset), 32'd1);
        check_value("pll_cause", 32'(reset_cause), 32'd2);
        count_until(1'b0, 50, n);
        check_value("pll_rerelease_edges", 32'(n), 32'd9);

`ifdef RESET_SEQ_WDT_EN
        count_until(1'b1, 200, n);
        check_value("wdt_expire_edges", 32'(n), 32'd100);
        check_value("wdt_cause", 32'(reset_cause), 32'd3);
        count_until(1'b0, 50, n);
        check_value("wdt_rerelease_edges", 32'(n), 32'd9);
`else
        seen = 1'b0;
        repeat (150) begin tick(); seen = seen | sys_reset; end
        check_value("no_wdt_idle", 32'(seen), 32'd0);
`endif

        // Kick every 50 cycles keeps RUN alive
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            repeat (49) begin tick(); seen = seen | sys_reset; end
            wdt_kick = 1'b1;
            tick();
            seen = seen | sys_reset;
            wdt_kick = 1'b0;
        end
        check_value("kick_no_reset", 32'(seen), 32'd0);
        check_value("kick_cause_held", 32'(reset_cause), 32'(CAUSE_AFTER_IDLE));

        // PLL loss and debounced key seen in the same cycle
        key_n = 1'b0;
        repeat (4) tick();
        pll_locked = 1'b0;
        repeat (2) tick();
        pll_locked = 1'b1;
        check_value("both_key_e6", 32'(key_pressed), 32'd1);
        check_value("both_sys_e6", 32'(sys_reset), 32'd0);
        tick();
        check_value("both_sys_e7", 32'(sys_reset), 32'd1);
        check_value("both_cause", 32'(reset_cause), 32'd2);
        repeat (3) tick();
        key_n = 1'b1;
        // Debounced release at edge 16, HOLD from 17, RUN at 25
        count_until(1'b0, 50, n);
        check_value("both_release_edges", 32'(n), 32'd15);

        // Reset arriving mid-HOLD
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        repeat (2) tick();
        check_value("midhold_pll_sys", 32'(sys_reset), 32'd1);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check_value("midhold_rst_sys", 32'(sys_reset), 32'd1);
        check_value("midhold_rst_cause", 32'(reset_cause), 32'd0);
        check_value("midhold_rst_key", 32'(key_pressed), 32'd0);
        reset = 1'b0;
        count_until(1'b0, 50, n);
        check_value("midhold_release_edges", 32'(n), 32'd11);
        check_value("midhold_final_cause", 32'(reset_cause), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

endmodule
